// File: rtl/cpu_fetch_queue_if.sv
// Instruction-bus read channel between the fetch queue (master) and the
// instruction memory (slave). Request/address are held by the master until
// the cycle ready is sampled high; rdata is valid in that same cycle.
interface cpu_fetch_queue_if;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic        i_bus_ready;
  logic [31:0] i_bus_rdata;

  modport master (
    output o_bus_request,
    output o_bus_address,
    input  i_bus_ready,
    input  i_bus_rdata
  );

  modport slave (
    input  o_bus_request,
    input  o_bus_address,
    output i_bus_ready,
    output i_bus_rdata
  );
endinterface

// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: instruction prefetcher with a DEPTH-entry queue.
// Fetches sequential words over the instruction bus, tags each pushed word
// with a wrapping push count, and stops at control-flow instructions until
// execute resolves the next PC (matched by tag). The head of the queue is
// presented on o_tag/o_instruction/o_pc; a new o_tag marks a new instruction.
// Optional build macro: CPU_FETCH_JAL_PREDICT_EN -- when defined, JAL is
// followed at push time (pc + J-immediate) instead of waiting for execute.
module cpu_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter int          TAG_WIDTH = 8,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_stall,
  cpu_fetch_queue_if.master    bus,
  input  logic [TAG_WIDTH-1:0] i_tag,
  input  logic [31:0]          i_pc_next,
  output logic [TAG_WIDTH-1:0] o_tag,
  output logic [31:0]          o_instruction,
  output logic [31:0]          o_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          pc;
    logic [31:0]          instr;
  } entry_t;

  typedef enum logic {
    S_FETCH,
    S_WAIT_BRANCH
  } state_e;

  // Queue storage (no reset needed: emptiness is tracked by count_q)
  entry_t mem_q [DEPTH];

  state_e               state_q,      state_d;
  logic [31:0]          fetch_pc_q,   fetch_pc_d;
  logic [TAG_WIDTH-1:0] push_cnt_q,   push_cnt_d;
  logic [TAG_WIDTH-1:0] branch_tag_q, branch_tag_d;
  logic [PW-1:0]        wr_ptr_q,     wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q,     rd_ptr_d;
  logic [CW-1:0]        count_q,      count_d;
  logic                 req_q,        req_d;
  entry_t               out_q,        out_d;

  logic   push;
  logic   pop;
  logic   is_ctrl;
  logic [6:0] opcode;
  entry_t push_entry;

  // A transfer completes when our held request meets ready
  assign push   = req_q & bus.i_bus_ready;
  assign pop    = (count_q != '0) & ~i_stall;
  assign opcode = bus.i_bus_rdata[6:0];

  assign is_ctrl = (opcode == OP_BRANCH) | (opcode == OP_JAL) |
                   (opcode == OP_JALR)   | (opcode == OP_SYSTEM);

  // Tag of a pushed word is the incremented push count, so the first
  // instruction after reset carries tag 1 and never aliases the reset o_tag
  assign push_entry.tag   = push_cnt_q + TAG_WIDTH'(1);
  assign push_entry.pc    = fetch_pc_q;
  assign push_entry.instr = bus.i_bus_rdata;

`ifdef CPU_FETCH_JAL_PREDICT_EN
  logic        is_jal;
  logic [31:0] jal_target;
  assign is_jal     = (opcode == OP_JAL);
  assign jal_target = fetch_pc_q + {{12{bus.i_bus_rdata[31]}}, bus.i_bus_rdata[19:12],
                                    bus.i_bus_rdata[20], bus.i_bus_rdata[30:21], 1'b0};
`endif

  // Next-state: fetch PC / FSM, queue pointers, presented entry, request
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    push_cnt_d   = push_cnt_q;
    branch_tag_d = branch_tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_d        = out_q;

    if (push) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      push_cnt_d = push_entry.tag;
      fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef CPU_FETCH_JAL_PREDICT_EN
      if (is_jal) begin
        fetch_pc_d = jal_target;
      end else if (is_ctrl) begin
        state_d      = S_WAIT_BRANCH;
        branch_tag_d = push_entry.tag;
      end
`else
      if (is_ctrl) begin
        state_d      = S_WAIT_BRANCH;
        branch_tag_d = push_entry.tag;
      end
`endif
    end

    // Request is low while waiting, so no push can race the redirect
    if ((state_q == S_WAIT_BRANCH) && (i_tag == branch_tag_q)) begin
      fetch_pc_d = i_pc_next;
      state_d    = S_FETCH;
    end

    if (pop) begin
      out_d    = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    // Registered request: computed from next state so it stays asserted with
    // a stable address until the transfer completes (PC and state only move
    // on a push or a redirect, neither of which can happen while pending)
    req_d = (state_d == S_FETCH) && (count_d < FULL);
  end

  // State register for control, pointers and presented instruction
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_PC;
      push_cnt_q   <= '0;
      branch_tag_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      req_q        <= 1'b0;
      out_q        <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      push_cnt_q   <= push_cnt_d;
      branch_tag_q <= branch_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      req_q        <= req_d;
      out_q        <= out_d;
    end
  end

  // Queue write; a ready seen during reset is dropped
  always_ff @(posedge i_clock) begin
    if (!i_reset && push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign bus.o_bus_request = req_q;
  assign bus.o_bus_address = fetch_pc_q;
  assign o_tag             = out_q.tag;
  assign o_instruction     = out_q.instr;
  assign o_pc              = out_q.pc;

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: a background bus model answers requests and
// pushes the expected {tag, pc, instr} into a scoreboard on each accepted
// transfer; a monitor pops and compares whenever o_tag changes. Directed
// sequences cover stall/refill, branch wait, JAL, bus latency and reset.
module tb_cpu_fetch_queue;
  localparam int TW    = 2;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [31:0]   pc;
    logic [31:0]   instr;
  } exp_t;

  typedef struct {
    int            lat;
    logic [31:0]   addr;
    logic [TW-1:0] tag;
    logic [31:0]   pc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic [TW-1:0] tag_in = '0;
  logic [31:0]   pc_next = '0;
  logic [TW-1:0] o_tag;
  logic [31:0]   o_instr;
  logic [31:0]   o_pc;

  cpu_fetch_queue_if bif();

  cpu_fetch_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .RESET_PC(32'h0)) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_stall      (stall),
    .bus          (bif),
    .i_tag        (tag_in),
    .i_pc_next    (pc_next),
    .o_tag        (o_tag),
    .o_instruction(o_instr),
    .o_pc         (o_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;      // 0: hold ready low, 1: auto responder, 2: manual
  int resp_lat = 0;
  int cyc = 0;

  exp_t          sb[$];
  logic [31:0]   addr_log[$];
  logic [TW-1:0] pop_tag_log[$];
  logic [31:0]   pop_pc_log[$];
  int            pop_cyc[$];
  logic [31:0]   prog [logic [31:0]];
  vec_t          vecs[6];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {a[11:0], 5'd0, 3'b000, 5'd1, 7'h13};  // addi x1, x0, imm
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_addrs(input int n, input int budget, input string name);
    int k = 0;
    while (addr_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(addr_log.size() >= n), 64'd1);
  endtask

  task automatic wait_pops(input int n, input int budget, input string name);
    int k = 0;
    while (pop_tag_log.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 64'(pop_tag_log.size() >= n), 64'd1);
  endtask

  task automatic do_reset(input logic st);
    mode  = 0;
    rst   = 1'b1;
    stall = st;
    repeat (3) tick();
    sb.delete();
    addr_log.delete();
    pop_tag_log.delete();
    pop_pc_log.delete();
    pop_cyc.delete();
    prog.delete();
    rst = 1'b0;
  endtask

  // Bus responder, scoreboard producer and output monitor
  initial begin : bus_model
    logic          p_acc, p_rst;
    logic [31:0]   p_addr, p_data;
    logic [TW-1:0] prev_tag, exp_tag;
    int            wcnt;
    exp_t          e;
    wcnt = 0;
    prev_tag = '0;
    exp_tag = '0;
    bif.i_bus_ready = 1'b0;
    bif.i_bus_rdata = '0;
    forever begin
      @(negedge clk);
      p_acc  = bif.i_bus_ready && bif.o_bus_request;
      p_rst  = rst;
      p_addr = bif.o_bus_address;
      p_data = bif.i_bus_rdata;
      @(posedge clk);
      #1;
      cyc++;
      if (p_rst) begin
        exp_tag  = '0;
        prev_tag = o_tag;
      end else begin
        if (p_acc) begin
          exp_tag++;
          e.tag = exp_tag;
          e.pc = p_addr;
          e.instr = p_data;
          sb.push_back(e);
          addr_log.push_back(p_addr);
        end
        if (o_tag !== prev_tag) begin
          prev_tag = o_tag;
          pop_tag_log.push_back(o_tag);
          pop_pc_log.push_back(o_pc);
          pop_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got tag %0d, want no new instruction", o_tag);
          end else begin
            e = sb.pop_front();
            check("present_tag", 64'(o_tag), 64'(e.tag));
            check("present_pc_instr", {o_pc, o_instr}, {e.pc, e.instr});
          end
        end
      end
      if (mode == 1) begin
        if (bif.o_bus_request) begin
          if (wcnt >= resp_lat) begin
            bif.i_bus_ready = 1'b1;
            bif.i_bus_rdata = word_at(bif.o_bus_address);
            wcnt = 0;
          end else begin
            bif.i_bus_ready = 1'b0;
            wcnt++;
          end
        end else begin
          bif.i_bus_ready = 1'b0;
          wcnt = 0;
        end
      end else if (mode == 0) begin
        bif.i_bus_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    for (int i = 0; i < 6; i++) begin
      vecs[i].addr = 32'(i * 4);
      vecs[i].pc   = 32'(i * 4);
      vecs[i].tag  = TW'(i + 1);
    end
    vecs[0].lat = 0; vecs[1].lat = 1; vecs[2].lat = 0;
    vecs[3].lat = 2; vecs[4].lat = 3; vecs[5].lat = 0;

    // Reset state and first request timing
    rst = 1'b1;
    repeat (3) tick();
    check("rst_req", 64'(bif.o_bus_request), 64'd0);
    check("rst_tag", 64'(o_tag), 64'd0);
    check("rst_pc", 64'(o_pc), 64'd0);
    check("rst_instr", 64'(o_instr), 64'd0);
    rst = 1'b0;
    check("rst_req_hold", 64'(bif.o_bus_request), 64'd0);
    tick();
    check("first_req", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h0}));

    // Sequential fetch with varying bus latency; tags wrap 1,2,3,0,1,2
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      resp_lat = vecs[i].lat;
      wait_addrs(i + 1, 40, "t1_fetch_done");
      if (addr_log.size() > i) check("t1_addr", 64'(addr_log[i]), 64'(vecs[i].addr));
      wait_pops(i + 1, 40, "t1_pop_done");
      if (pop_tag_log.size() > i) begin
        check("t1_tag", 64'(pop_tag_log[i]), 64'(vecs[i].tag));
        check("t1_pc", 64'(pop_pc_log[i]), 64'(vecs[i].pc));
      end
    end
    resp_lat = 0;

    // Stall: fill exactly DEPTH, then drain on consecutive cycles and refill
    do_reset(1'b1);
    mode = 1;
    repeat (20) tick();
    check("t2_reads", 64'(addr_log.size()), 64'(DEPTH));
    check("t2_req_low", 64'(bif.o_bus_request), 64'd0);
    check("t2_no_pop", 64'(pop_tag_log.size()), 64'd0);
    stall = 1'b0;
    wait_pops(4, 20, "t2_pops_done");
    if (pop_cyc.size() >= 4) begin
      for (int j = 0; j < 3; j++) check("t2_consecutive", 64'(pop_cyc[j+1] - pop_cyc[j]), 64'd1);
    end
    wait_addrs(5, 20, "t2_refill");
    if (addr_log.size() >= 5) check("t2_refill_addr", 64'(addr_log[4]), 64'h10);

    // Branch at 0x10 stops fetch until its tag resolves to 0x40
    do_reset(1'b0);
    prog[32'h10] = 32'h0000_0063;  // beq x0, x0, 0
    tag_in  = TW'(2);
    pc_next = 32'h80;
    mode = 1;
    wait_addrs(5, 40, "t3_fetch_to_branch");
    repeat (10) tick();
    check("t3_no_fetch_14", 64'(addr_log.size()), 64'd5);
    check("t3_req_low", 64'(bif.o_bus_request), 64'd0);
    if (addr_log.size() >= 5) check("t3_branch_addr", 64'(addr_log[4]), 64'h10);
    tag_in  = TW'(1);
    pc_next = 32'h40;
    tick();
    tag_in = TW'(2);
    wait_addrs(6, 20, "t3_resume");
    if (addr_log.size() >= 6) check("t3_target", 64'(addr_log[5]), 64'h40);

    // JAL +0x100 at 0x20
    do_reset(1'b0);
    prog[32'h20] = 32'h1000_006F;  // jal x0, +0x100
    tag_in = TW'(2);
    mode = 1;
    wait_addrs(9, 60, "t4_fetch_to_jal");
`ifdef CPU_FETCH_JAL_PREDICT_EN
    wait_addrs(10, 20, "t4_predict");
    if (addr_log.size() >= 10) check("t4_jal_target", 64'(addr_log[9]), 64'h120);
`else
    repeat (10) tick();
    check("t4_jal_waits", 64'(addr_log.size()), 64'd9);
    check("t4_req_low", 64'(bif.o_bus_request), 64'd0);
    tag_in  = TW'(1);
    pc_next = 32'h24;
    tick();
    tag_in = TW'(2);
    wait_addrs(10, 20, "t4_resume");
    if (addr_log.size() >= 10) check("t4_resolved", 64'(addr_log[9]), 64'h24);
`endif

    // Slow bus: address held; reset mid-transfer discards the ready
    do_reset(1'b1);
    mode = 2;
    bif.i_bus_ready = 1'b0;
    tick();
    check("t5_req_rise", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h0}));
    for (int j = 0; j < 3; j++) begin
      tick();
      check("t5_addr_stable", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h0}));
    end
    bif.i_bus_rdata = word_at(32'h0);
    bif.i_bus_ready = 1'b1;
    tick();
    bif.i_bus_ready = 1'b0;
    check("t5_b2b", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h4}));
    check("t5_accepted", 64'(addr_log.size()), 64'd1);
    tick();
    check("t5_addr_stable2", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h4}));
    rst = 1'b1;
    bif.i_bus_rdata = word_at(32'h4);
    bif.i_bus_ready = 1'b1;
    tick();
    bif.i_bus_ready = 1'b0;
    rst = 1'b0;
    stall = 1'b0;
    check("t5_rst_req", 64'(bif.o_bus_request), 64'd0);
    check("t5_rst_tag", 64'(o_tag), 64'd0);
    repeat (5) tick();
    check("t5_queue_empty", 64'(o_tag), 64'd0);
    check("t5_no_accept", 64'(addr_log.size()), 64'd1);
    check("t5_pc_reset", 64'({bif.o_bus_request, bif.o_bus_address}), 64'({1'b1, 32'h0}));
    mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_queue.md
CPU_FETCH_QUEUE -- requirements
Module: cpu_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: instruction queue entries; power of two, 2..16.
REQ-002 SHALL have parameter TAG_WIDTH, default 8: width of all tag ports and registers.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-004 SHALL have port i_clock  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port i_stall  in  1  downstream busy; no instruction is presented while high.
REQ-007 SHALL have port o_bus_request  out  1  instruction bus read request.
REQ-008 SHALL have port i_bus_ready  in  1  bus read complete; i_bus_rdata valid this cycle.
REQ-009 SHALL have port o_bus_address  out  32  read address.
REQ-010 SHALL have port i_bus_rdata  in  32  read data.
REQ-011 SHALL have port i_tag  in  TAG_WIDTH  tag of the instruction just resolved by execute.
REQ-012 SHALL have port i_pc_next  in  32  resolved next PC, qualified by i_tag.
REQ-013 SHALL have ports o_tag (TAG_WIDTH), o_instruction (32), o_pc (32), all out: presented instruction; a change of o_tag marks a new instruction.

Function
REQ-014 SHALL hold a DEPTH-entry FIFO of {tag, pc, instruction}; entry tag = push counter value, counter incremented per push, wrapping modulo 2^TAG_WIDTH.
REQ-015 SHALL run two states, FETCH and WAIT_BRANCH.
REQ-016 In FETCH, o_bus_request SHALL be high whenever the queue holds fewer than DEPTH entries, with o_bus_address = fetch PC.
REQ-017 o_bus_request and o_bus_address SHALL stay stable from assertion until the cycle i_bus_ready is sampled high.
REQ-018 On i_bus_ready, SHALL push the entry and advance fetch PC by 4 (32-bit wrap); request MAY stay high next cycle for back-to-back reads.
REQ-019 A pushed word with opcode [6:0] in {1100011, 1101111, 1100111, 1110011} SHALL be a control instruction; SHALL record its tag as branch_tag and enter WAIT_BRANCH with request low.
REQ-020 In WAIT_BRANCH, when i_tag == branch_tag, SHALL load fetch PC with i_pc_next and return to FETCH next cycle.
REQ-021 When the queue is non-empty and i_stall is low, SHALL pop the head into o_tag/o_instruction/o_pc at the next edge; one pop per cycle max.
REQ-022 Push and pop in the same cycle SHALL both occur; a push into a full queue SHALL not occur (request is low).
REQ-023 Push into an empty queue SHALL be presentable no earlier than the following cycle (1-cycle queue latency).
REQ-024 i_tag/i_pc_next SHALL be ignored in FETCH.

Reset
REQ-025 On i_reset: fetch PC = RESET_PC, state FETCH, queue empty, push counter 0, branch_tag 0, o_tag 0, o_instruction 0, o_pc 0, o_bus_request 0.
REQ-026 Reset mid-transfer SHALL drop o_bus_request the next cycle and discard any i_bus_ready that cycle.
REQ-027 First request SHALL assert in the cycle after reset deasserts.

Configuration
REQ-028 Macro CPU_FETCH_JAL_PREDICT_EN: when defined, opcode 1101111 (JAL) SHALL NOT enter WAIT_BRANCH; fetch PC SHALL become pc + sign-extended J-immediate at push, fetching continues.
REQ-029 Without CPU_FETCH_JAL_PREDICT_EN, JAL SHALL be handled per REQ-019/020.

Verification
REQ-030 Reset, bus returns ADDI words with 0-wait ready, i_stall low -> addresses 0,4,8,...; o_tag 1,2,3 with o_pc 0,4,8.
REQ-031 DEPTH=4, i_stall high 20 cycles -> exactly 4 reads then request low; release -> 4 pops on consecutive cycles, then refill.
REQ-032 BEQ at 0x10 -> request low after its push; i_tag=that tag, i_pc_next=0x40 -> next address 0x40, no fetch of 0x14.
REQ-033 With CPU_FETCH_JAL_PREDICT_EN, JAL +0x100 at 0x20 -> next address 0x120 without i_tag match; without macro -> waits.
REQ-034 Bus ready delayed 3 cycles -> address stable throughout; reset asserted in cycle 2 -> request low, queue empty, o_tag 0.
REQ-035 TAG_WIDTH=2, 6 sequential instructions -> o_tag sequence 1,2,3,0,1,2.
